// File: rtl/fibo_job_sequencer.sv
// fibo_job_sequencer
//   Request/response front end for the Fibonacci calculator. It accepts a
//   term-count job on a valid/ready request port and launches the calculator
//   with a one-cycle START and a latched COUNT. It then waits for DONE and
//   returns the captured DATA on a valid/ready response port. If DONE never
//   arrives, it returns a timeout error instead.
//
//   Optional build macro: FIBO_SEQ_STATS_EN adds saturating JOB_CNT/ERR_CNT.
//
// Ports:
//   CLK, RST         clock (rising edge), async reset active-low
//   REQ_VALID/READY  job request handshake, REQ_COUNT = term count
//   START, COUNT     launch pulse and latched term count to the calculator
//   DONE, DATA       calculator completion level and result
//   RES_VALID/READY  response handshake, RES_DATA result, RES_ERR timeout flag
//   BUSY             high whenever a job is in flight or a result is held
//   JOB_CNT, ERR_CNT (FIBO_SEQ_STATS_EN only) response / error handshake counts
module fibo_job_sequencer #(
    parameter int SIZE    = 4,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [SIZE-1:0] REQ_COUNT,
    output logic            START,
    output logic [SIZE-1:0] COUNT,
    input  logic            DONE,
    input  logic [SIZE-1:0] DATA,
    output logic            RES_VALID,
    input  logic            RES_READY,
    output logic [SIZE-1:0] RES_DATA,
    output logic            RES_ERR,
    output logic            BUSY
`ifdef FIBO_SEQ_STATS_EN
    ,
    output logic [7:0]      JOB_CNT,
    output logic [7:0]      ERR_CNT
`endif
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer;
    logic            armed;

    logic accept, res_hs, done_hit, timeout_hit;

    // REQ_READY is a registered copy of (state == IDLE), so it can gate accept
    assign accept      = REQ_VALID & REQ_READY;
    assign res_hs      = RES_VALID & RES_READY;
    assign done_hit    = armed & DONE;
    assign timeout_hit = (timer == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (REQ_COUNT == '0) ? HOLD : LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (done_hit || timeout_hit) state_nxt = HOLD;
            HOLD:    if (res_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake/strobe outputs are decoded from the next state so they appear
    // on the same edge as the transition that causes them.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            REQ_READY <= 1'b0;
            START     <= 1'b0;
            RES_VALID <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state     <= state_nxt;
            REQ_READY <= (state_nxt == IDLE);
            START     <= (state_nxt == LAUNCH);
            RES_VALID <= (state_nxt == HOLD);
            BUSY      <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            COUNT    <= '0;
            RES_DATA <= '0;
            RES_ERR  <= 1'b0;
            timer    <= '0;
            armed    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (REQ_COUNT == '0) begin
                            // zero-term job completes without touching the calculator
                            RES_DATA <= '0;
                            RES_ERR  <= 1'b0;
                        end else begin
                            COUNT <= REQ_COUNT;
                        end
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    armed <= 1'b0;
                end
                WAIT: begin
                    // DONE may still be high from the previous job; only trust it
                    // after it has been seen low once in this job.
                    if (!DONE) armed <= 1'b1;
                    if (done_hit) begin
                        RES_DATA <= DATA;
                        RES_ERR  <= 1'b0;
                    end else if (timeout_hit) begin
                        RES_DATA <= '0;
                        RES_ERR  <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIBO_SEQ_STATS_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            JOB_CNT <= '0;
            ERR_CNT <= '0;
        end else if (res_hs) begin
            if (JOB_CNT != 8'hFF) JOB_CNT <= JOB_CNT + 8'd1;
            if (RES_ERR && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fibo_job_sequencer.sv
module tb_fibo_job_sequencer;
    logic       CLK, RST, REQ_VALID, REQ_READY, START, DONE, RES_VALID, RES_READY, RES_ERR, BUSY;
    logic [3:0] REQ_COUNT, COUNT, DATA, RES_DATA;
`ifdef FIBO_SEQ_STATS_EN
    logic [7:0] JOB_CNT, ERR_CNT;
`endif

    int vectors = 0;
    int miscompares = 0;
    int start_seen = 0;

    fibo_job_sequencer #(.SIZE(4), .TIMEOUT(64), .TW(7)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_COUNT(REQ_COUNT),
        .START(START), .COUNT(COUNT), .DONE(DONE), .DATA(DATA),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
        .RES_ERR(RES_ERR), .BUSY(BUSY)
`ifdef FIBO_SEQ_STATS_EN
        , .JOB_CNT(JOB_CNT), .ERR_CNT(ERR_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // advance to the next falling edge (outputs settled) and tally START pulses
    task automatic tick();
        @(negedge CLK);
        start_seen = start_seen + int'(START);
    endtask

    task automatic release_result();
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; REQ_VALID = 1'b0; REQ_COUNT = '0; DONE = 1'b0; DATA = '0; RES_READY = 1'b0;
        tick(); tick();
        vectors++; if ({REQ_READY, START, RES_VALID, RES_ERR, BUSY} !== 5'b0) begin miscompares++; $display("FAIL reset_flags got %b want 00000", {REQ_READY, START, RES_VALID, RES_ERR, BUSY}); end
        vectors++; if ({COUNT, RES_DATA} !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", {COUNT, RES_DATA}); end
        RST = 1'b1;
        vectors++; if (REQ_READY !== 1'b0) begin miscompares++; $display("FAIL ready_before_edge got %b want 0", REQ_READY); end
        tick();
        vectors++; if (REQ_READY !== 1'b1) begin miscompares++; $display("FAIL ready_after_release got %b want 1", REQ_READY); end
    endtask

    task automatic test_normal_job();
        start_seen = 0;
        REQ_VALID = 1'b1; REQ_COUNT = 4'd5;
        tick();
        REQ_VALID = 1'b0;
        vectors++; if (START !== 1'b1) begin miscompares++; $display("FAIL job_start got %b want 1", START); end
        vectors++; if (COUNT !== 4'd5) begin miscompares++; $display("FAIL job_count got %0d want 5", COUNT); end
        vectors++; if ({REQ_READY, BUSY} !== 2'b01) begin miscompares++; $display("FAIL job_ready_busy got %b want 01", {REQ_READY, BUSY}); end
        tick();
        vectors++; if (START !== 1'b0) begin miscompares++; $display("FAIL job_start_one_cycle got %b want 0", START); end
        tick(); tick();
        vectors++; if (RES_VALID !== 1'b0) begin miscompares++; $display("FAIL job_early_valid got %b want 0", RES_VALID); end
        DONE = 1'b1; DATA = 4'd5;
        tick();
        vectors++; if ({RES_VALID, RES_ERR, BUSY} !== 3'b101) begin miscompares++; $display("FAIL job_result_flags got %b want 101", {RES_VALID, RES_ERR, BUSY}); end
        vectors++; if (RES_DATA !== 4'd5) begin miscompares++; $display("FAIL job_res_data got %0d want 5", RES_DATA); end
        tick();
        vectors++; if ({RES_VALID, BUSY} !== 2'b11) begin miscompares++; $display("FAIL job_hold got %b want 11", {RES_VALID, BUSY}); end
        vectors++; if (start_seen !== 1) begin miscompares++; $display("FAIL job_start_pulses got %0d want 1", start_seen); end
        release_result();
        vectors++; if ({REQ_READY, RES_VALID, BUSY} !== 3'b100) begin miscompares++; $display("FAIL job_release got %b want 100", {REQ_READY, RES_VALID, BUSY}); end
        DONE = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        start_seen = 0;
        REQ_VALID = 1'b1; REQ_COUNT = 4'd7;
        tick();
        REQ_VALID = 1'b0;
        n = 0;
        while (RES_VALID !== 1'b1 && n < 200) begin tick(); n++; end
        // one edge into WAIT, then 64 WAIT cycles
        vectors++; if (n !== 65) begin miscompares++; $display("FAIL timeout_latency got %0d want 65", n); end
        vectors++; if ({RES_ERR, RES_DATA} !== 5'b1_0000) begin miscompares++; $display("FAIL timeout_result got err=%b data=%0d want err=1 data=0", RES_ERR, RES_DATA); end
        vectors++; if (start_seen !== 1) begin miscompares++; $display("FAIL timeout_start_pulses got %0d want 1", start_seen); end
        release_result();
        vectors++; if (REQ_READY !== 1'b1) begin miscompares++; $display("FAIL timeout_release got %b want 1", REQ_READY); end
    endtask

    task automatic test_zero_count();
        start_seen = 0;
        REQ_VALID = 1'b1; REQ_COUNT = 4'd0;
        tick();
        REQ_VALID = 1'b0;
        vectors++; if ({RES_VALID, RES_ERR, BUSY, START} !== 4'b1010) begin miscompares++; $display("FAIL zero_flags got %b want 1010", {RES_VALID, RES_ERR, BUSY, START}); end
        vectors++; if (RES_DATA !== 4'd0) begin miscompares++; $display("FAIL zero_data got %0d want 0", RES_DATA); end
        release_result();
        vectors++; if (start_seen !== 0) begin miscompares++; $display("FAIL zero_no_start got %0d want 0", start_seen); end
        vectors++; if ({REQ_READY, RES_VALID} !== 2'b10) begin miscompares++; $display("FAIL zero_release got %b want 10", {REQ_READY, RES_VALID}); end
    endtask

    task automatic test_stale_done();
        DONE = 1'b1; DATA = 4'd3;
        REQ_VALID = 1'b1; REQ_COUNT = 4'd7;
        tick();
        REQ_VALID = 1'b0;
        tick(); tick();
        vectors++; if (RES_VALID !== 1'b0) begin miscompares++; $display("FAIL stale_ignored got %b want 0", RES_VALID); end
        DONE = 1'b0;
        tick();
        DONE = 1'b1; DATA = 4'd13;
        tick();
        vectors++; if (RES_VALID !== 1'b1) begin miscompares++; $display("FAIL stale_valid got %b want 1", RES_VALID); end
        vectors++; if (RES_DATA !== 4'd13) begin miscompares++; $display("FAIL stale_data got %0d want 13", RES_DATA); end
        release_result();
    endtask

    task automatic test_back_to_back();
        DONE = 1'b0;
        REQ_VALID = 1'b1; REQ_COUNT = 4'd2;
        tick();
        REQ_VALID = 1'b0;
        tick(); tick();
        DONE = 1'b1; DATA = 4'd1;
        tick();
        REQ_VALID = 1'b1; REQ_COUNT = 4'd9;
        for (int i = 0; i < 10; i++) begin
            DATA = 4'(i + 4);
            tick();
            vectors++; if ({RES_VALID, REQ_READY, RES_DATA} !== 6'b10_0001) begin miscompares++; $display("FAIL hold_stable[%0d] got v=%b rdy=%b data=%0d want v=1 rdy=0 data=1", i, RES_VALID, REQ_READY, RES_DATA); end
            vectors++; if (COUNT !== 4'd2) begin miscompares++; $display("FAIL hold_count[%0d] got %0d want 2", i, COUNT); end
        end
        release_result();
        vectors++; if ({REQ_READY, RES_VALID} !== 2'b10) begin miscompares++; $display("FAIL b2b_release got %b want 10", {REQ_READY, RES_VALID}); end
        tick();
        REQ_VALID = 1'b0;
        vectors++; if ({START, COUNT} !== 5'b1_1001) begin miscompares++; $display("FAIL b2b_launch got start=%b count=%0d want start=1 count=9", START, COUNT); end
        DONE = 1'b0;
        tick(); tick();
        DONE = 1'b1; DATA = 4'd2;
        tick();
        vectors++; if ({RES_VALID, RES_DATA} !== 5'b1_0010) begin miscompares++; $display("FAIL b2b_result got v=%b data=%0d want v=1 data=2", RES_VALID, RES_DATA); end
        release_result();
        DONE = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        REQ_VALID = 1'b1; REQ_COUNT = 4'd3;
        tick();
        REQ_VALID = 1'b0;
        tick(); tick();
        RST = 1'b0;
        #1;
        vectors++; if ({REQ_READY, START, RES_VALID, RES_ERR, BUSY} !== 5'b0) begin miscompares++; $display("FAIL abort_flags got %b want 00000", {REQ_READY, START, RES_VALID, RES_ERR, BUSY}); end
        vectors++; if ({COUNT, RES_DATA} !== 8'h00) begin miscompares++; $display("FAIL abort_data got %h want 00", {COUNT, RES_DATA}); end
`ifdef FIBO_SEQ_STATS_EN
        vectors++; if ({JOB_CNT, ERR_CNT} !== 16'h0) begin miscompares++; $display("FAIL abort_stats got %h want 0000", {JOB_CNT, ERR_CNT}); end
`endif
        tick();
        RST = 1'b1;
        tick();
        vectors++; if ({REQ_READY, RES_VALID} !== 2'b10) begin miscompares++; $display("FAIL abort_recover got %b want 10", {REQ_READY, RES_VALID}); end
        start_seen = 0;
        REQ_VALID = 1'b1; REQ_COUNT = 4'd4;
        tick();
        REQ_VALID = 1'b0;
        vectors++; if ({START, COUNT} !== 5'b1_0100) begin miscompares++; $display("FAIL recover_launch got start=%b count=%0d want start=1 count=4", START, COUNT); end
        tick(); tick();
        DONE = 1'b1; DATA = 4'd3;
        tick();
        vectors++; if ({RES_VALID, RES_ERR, RES_DATA} !== 6'b10_0011) begin miscompares++; $display("FAIL recover_result got v=%b err=%b data=%0d want v=1 err=0 data=3", RES_VALID, RES_ERR, RES_DATA); end
        release_result();
        vectors++; if ({REQ_READY, BUSY, start_seen[0]} !== 3'b101) begin miscompares++; $display("FAIL recover_done got %b want 101", {REQ_READY, BUSY, start_seen[0]}); end
`ifdef FIBO_SEQ_STATS_EN
        vectors++; if ({JOB_CNT, ERR_CNT} !== 16'h0100) begin miscompares++; $display("FAIL recover_stats got %h want 0100", {JOB_CNT, ERR_CNT}); end
`endif
        DONE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal_job();
        test_timeout();
        test_zero_count();
        test_stale_done();
        test_back_to_back();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
